// File: rtl/riscv_mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter in front of a single-port,
// fixed-latency memory. One transaction is in flight at a time; contention is round-robin.
module riscv_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [3:0]    ls_be,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      cnt_reg, cnt_next;
    logic            last_ls_reg;
    logic            owner_ls_reg;
    logic            we_reg;
    logic [3:0]      be_reg;
    logic [AW-1:0]   addr_reg;
    logic [DW-1:0]   wdata_reg;
    logic [DW-1:0]   rdata_reg;
    logic            grant_if, grant_ls, grant_any;
    logic            resp_cycle;
    logic            capture;

    // Grants are combinational and masked by reset so every output is 0 while held in reset.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (reset && state_reg == IDLE) begin
            if (if_req && ls_req) begin
                grant_ls = ~last_ls_reg;
                grant_if = last_ls_reg;
            end else begin
                grant_if = if_req;
                grant_ls = ls_req;
            end
        end
    end

    assign grant_any = grant_if | grant_ls;

    // WAIT spans MEM_LAT cycles so the capture lands on the cycle mem_rdata is valid.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
                cnt_next   = 3'(MEM_LAT - 1);
            end
            WAIT: begin
                if (cnt_reg == 3'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign capture = (state_reg == WAIT) && (cnt_reg == 3'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 3'd0;
            last_ls_reg  <= 1'b0;
            owner_ls_reg <= 1'b0;
            we_reg       <= 1'b0;
            be_reg       <= 4'h0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (grant_any) begin
                last_ls_reg  <= grant_ls;
                owner_ls_reg <= grant_ls;
                we_reg       <= grant_ls & ls_we;
                be_reg       <= grant_ls ? ls_be : 4'hF;
                addr_reg     <= grant_ls ? ls_addr : if_addr;
                wdata_reg    <= grant_ls ? ls_wdata : '0;
            end
            if (capture) begin
                rdata_reg <= mem_rdata;
            end
        end
    end

    assign if_gnt     = grant_if;
    assign ls_gnt     = grant_ls;
    assign busy       = (state_reg != IDLE);

    assign mem_req    = (state_reg == ISSUE);
    assign mem_we     = mem_req & we_reg;
    assign mem_be     = mem_req ? be_reg : 4'h0;
    assign mem_addr   = mem_req ? addr_reg : '0;
    assign mem_wdata  = mem_req ? wdata_reg : '0;

    // Stores still get an rvalid acknowledge but never return data.
    assign resp_cycle = (state_reg == RESP);
    assign if_rvalid  = resp_cycle & ~owner_ls_reg;
    assign ls_rvalid  = resp_cycle & owner_ls_reg;
    assign if_rdata   = if_rvalid ? rdata_reg : '0;
    assign ls_rdata   = (ls_rvalid & ~we_reg) ? rdata_reg : '0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed scenarios plus random traffic, all checked
// cycle-by-cycle against a transaction-level model; two extra instances cover MEM_LAT 1 and 4.
module tb_riscv_mem_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [3:0]  ls_be;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
    logic [31:0] if_rdata, ls_rdata;
    logic        mem_req, mem_we, busy;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory environment: 16 words aliased on addr[5:2], read data valid L cycles after mem_req.
    function automatic logic [31:0] init_word(int i);
        return (i == 4) ? 32'h0050_0093 : (32'hC0DE_0000 | (32'(i) * 32'h0101));
    endfunction

    logic [31:0] mem_env [16];
    logic        env_ready = 1'b0;
    logic [31:0] junk;
    logic        p_v [L];
    logic [3:0]  p_a [L];

    always @(posedge clk) begin
        junk <= $urandom;
        if (!reset && !env_ready) begin
            for (int i = 0; i < 16; i++) mem_env[i] <= init_word(i);
            env_ready <= 1'b1;
        end else if (mem_req && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem_env[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        p_v[0] <= mem_req && !mem_we;
        p_a[0] <= mem_addr[5:2];
        for (int i = 1; i < L; i++) begin
            p_v[i] <= p_v[i-1];
            p_a[i] <= p_a[i-1];
        end
    end

    assign mem_rdata = p_v[L-1] ? mem_env[p_a[L-1]] : junk;

    // Extra instances with MEM_LAT=1 (index 0) and MEM_LAT=4 (index 1), IF port only.
    logic [1:0]       x_req, x_gnt, x_rvalid, x_ls_gnt, x_ls_rvalid, x_mreq, x_mwe, x_busy;
    logic [1:0][31:0] x_addr, x_rdata, x_ls_rdata, x_maddr, x_mwdata, x_mrdata;
    logic [1:0][3:0]  x_mbe;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lat
            localparam int LAT = (gi == 0) ? 1 : 4;
            logic        pv [LAT];
            logic [31:0] pa [LAT];

            riscv_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_lat (
                .clk(clk), .reset(reset),
                .if_req(x_req[gi]), .if_addr(x_addr[gi]), .if_gnt(x_gnt[gi]),
                .if_rvalid(x_rvalid[gi]), .if_rdata(x_rdata[gi]),
                .ls_req(1'b0), .ls_we(1'b0), .ls_be(4'h0), .ls_addr(32'h0),
                .ls_wdata(32'h0), .ls_gnt(x_ls_gnt[gi]), .ls_rvalid(x_ls_rvalid[gi]),
                .ls_rdata(x_ls_rdata[gi]),
                .mem_req(x_mreq[gi]), .mem_we(x_mwe[gi]), .mem_be(x_mbe[gi]),
                .mem_addr(x_maddr[gi]), .mem_wdata(x_mwdata[gi]), .mem_rdata(x_mrdata[gi]),
                .busy(x_busy[gi])
            );

            always @(posedge clk) begin
                pv[0] <= x_mreq[gi];
                pa[0] <= x_maddr[gi];
                for (int i = 1; i < LAT; i++) begin
                    pv[i] <= pv[i-1];
                    pa[i] <= pa[i-1];
                end
            end

            assign x_mrdata[gi] = pv[LAT-1] ? (pa[LAT-1] ^ 32'h5A5A_0000) : 32'hBAD0_BAD0;
        end
    endgenerate

    // Reference model: one outstanding transaction, described by its grant cycle.
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc;
    int          m_free_at, m_g;
    bit          m_active, m_last_ls, m_owner_ls, m_we;
    bit          m_gnt_if_prev, m_gnt_ls_prev;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [31:0] ref_mem [16];

    int          s_cyc;
    logic        s_if_gnt, s_ls_gnt, s_busy, s_mem_req, s_mem_we, s_if_rvalid, s_ls_rvalid;
    logic [31:0] s_mem_addr, s_mem_wdata, s_if_rdata, s_ls_rdata;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active      = 1'b0;
        m_last_ls     = 1'b0;
        m_free_at     = 0;
        m_g           = -100;
        m_gnt_if_prev = 1'b0;
        m_gnt_ls_prev = 1'b0;
    endtask

    // Called at posedge+1 with inputs already applied; compares cycle cyc, returns at next posedge+1.
    task automatic step();
        logic        e_ig, e_lg, e_busy, e_mreq, e_irv, e_lrv, ls_win;
        logic [31:0] tmp;
        int          ph;
        @(negedge clk);
        e_ig = 1'b0;
        e_lg = 1'b0;
        if (cyc >= m_free_at && (if_req || ls_req)) begin
            ls_win     = ls_req && (!if_req || !m_last_ls);
            e_lg       = ls_win;
            e_ig       = !ls_win;
            m_active   = 1'b1;
            m_g        = cyc;
            m_owner_ls = ls_win;
            m_we       = ls_win && ls_we;
            m_be       = ls_win ? ls_be : 4'hF;
            m_addr     = ls_win ? ls_addr : if_addr;
            m_wdata    = ls_win ? ls_wdata : 32'h0;
            m_last_ls  = ls_win;
            m_free_at  = cyc + 3 + L;
            tmp        = ref_mem[m_addr[5:2]];
            m_rdata    = m_we ? 32'h0 : tmp;
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) tmp[8*b +: 8] = m_wdata[8*b +: 8];
                ref_mem[m_addr[5:2]] = tmp;
            end
            $display("txn cyc=%0d %s %s addr=%08h be=%h wdata=%08h", cyc,
                     ls_win ? "LS" : "IF", m_we ? "WR" : "RD", m_addr, m_be, m_wdata);
        end
        m_gnt_if_prev = e_ig;
        m_gnt_ls_prev = e_lg;
        ph     = cyc - m_g;
        e_busy = m_active && ph >= 1 && ph <= L + 2;
        e_mreq = m_active && ph == 1;
        e_irv  = m_active && ph == L + 2 && !m_owner_ls;
        e_lrv  = m_active && ph == L + 2 && m_owner_ls;

        s_cyc = cyc;
        s_if_gnt = if_gnt;   s_ls_gnt = ls_gnt;   s_busy = busy;
        s_mem_req = mem_req; s_mem_we = mem_we;   s_mem_addr = mem_addr; s_mem_wdata = mem_wdata;
        s_if_rvalid = if_rvalid; s_ls_rvalid = ls_rvalid;
        s_if_rdata = if_rdata;   s_ls_rdata = ls_rdata;

        check_val("if_gnt", if_gnt, e_ig);
        check_val("ls_gnt", ls_gnt, e_lg);
        check_val("busy", busy, e_busy);
        check_val("mem_req", mem_req, e_mreq);
        check_val("mem_cmd", {mem_we, mem_be, mem_addr}, e_mreq ? {m_we, m_be, m_addr} : 37'h0);
        check_val("mem_wdata", mem_wdata, e_mreq ? m_wdata : 32'h0);
        check_val("if_rvalid", if_rvalid, e_irv);
        check_val("if_rdata", if_rdata, e_irv ? m_rdata : 32'h0);
        check_val("ls_rvalid", ls_rvalid, e_lrv);
        check_val("ls_rdata", ls_rdata, e_lrv ? m_rdata : 32'h0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases at a posedge+1 (cycle 0).
    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check_val("rst_async_zero", |{if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
                                      mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy}, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_hold_zero", |{if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
                                     mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy}, 1'b0);
        model_reset();
        reset = 1'b1;
        cyc   = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h100 | ($urandom & 32'h000F_F000) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    int q_gnt [$];
    int first_gnt, n_rv;
    int gc [2], rc [2], nrv [2];
    logic [31:0] rd [2];

    initial begin
        reset = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
        x_req = 2'b00; x_addr[0] = 32'h0; x_addr[1] = 32'h0;
        cyc = 0;
        model_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

        // Both ports held from reset: LS, IF, LS, IF at 0, 5, 10, 15.
        if_req = 1'b1; if_addr = 32'h200;
        ls_req = 1'b1; ls_addr = 32'h104; ls_we = 1'b0; ls_be = 4'hF;
        @(posedge clk);
        #1;
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            step();
            if (s_if_gnt) q_gnt.push_back(s_cyc * 2);
            if (s_ls_gnt) q_gnt.push_back(s_cyc * 2 + 1);
        end
        check_val("rr_count", q_gnt.size(), 4);
        if (q_gnt.size() == 4) begin
            check_val("rr_0", q_gnt[0], 1);
            check_val("rr_1", q_gnt[1], 10);
            check_val("rr_2", q_gnt[2], 21);
            check_val("rr_3", q_gnt[3], 30);
        end

        // Single fetch of 0x10.
        if_req = 1'b1; if_addr = 32'h10; ls_req = 1'b0;
        apply_reset();
        step();
        check_val("a_gnt", s_if_gnt, 1'b1);
        if_req = 1'b0; if_addr = 32'h999;
        step();
        check_val("a_mem", {s_mem_req, s_mem_we, s_mem_addr}, {1'b1, 1'b0, 32'h10});
        check_val("a_busy1", s_busy, 1'b1);
        step();
        step();
        step();
        check_val("a_rvalid", s_if_rvalid, 1'b1);
        check_val("a_rdata", s_if_rdata, 32'h0050_0093);

        // Store then load of 0x100.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'hF;
        step();
        check_val("b_gnt", s_ls_gnt, 1'b1);
        ls_req = 1'b0; ls_wdata = 32'h1234_5678;
        step();
        check_val("b_mem_we", s_mem_we, 1'b1);
        check_val("b_mem_wdata", s_mem_wdata, 32'hDEAD_BEEF);
        step();
        step();
        step();
        check_val("b_ack", {s_ls_rvalid, s_ls_rdata}, {1'b1, 32'h0});
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
        step();
        ls_req = 1'b0;
        repeat (4) step();
        check_val("b_load", {s_ls_rvalid, s_ls_rdata}, {1'b1, 32'hDEAD_BEEF});

        // Fetch raised two cycles into a load is held off until G+5.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h104;
        step();
        ls_req = 1'b0;
        step();
        if_req = 1'b1; if_addr = 32'h108;
        first_gnt = -1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (s_if_gnt) begin
                first_gnt = s_cyc;
                break;
            end
        end
        check_val("c_gnt_cyc", first_gnt, 20);
        if_req = 1'b0;
        step();

        // Reset in cycle 2 of a fetch, request already waiting at release.
        if_req = 1'b1; if_addr = 32'h10;
        apply_reset();
        step();
        check_val("e_regrant", s_if_gnt, 1'b1);
        if_req = 1'b0;
        n_rv = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (s_if_rvalid) n_rv++;
        end
        check_val("e_rvalid_cnt", n_rv, 1);

        // Random traffic.
        for (int k = 0; k < 800; k++) begin
            if (if_req && !m_gnt_if_prev) begin
                if ($urandom_range(0, 99) < 3) if_req = 1'b0;
            end else begin
                if_req  = ($urandom_range(0, 99) < 40);
                if_addr = rand_addr();
            end
            if (ls_req && !m_gnt_ls_prev) begin
                if ($urandom_range(0, 99) < 3) ls_req = 1'b0;
            end else begin
                ls_req   = ($urandom_range(0, 99) < 40);
                ls_we    = 1'($urandom_range(0, 1));
                ls_be    = 4'($urandom);
                ls_addr  = rand_addr();
                ls_wdata = $urandom;
            end
            step();
        end
        if_req = 1'b0;
        ls_req = 1'b0;

        // MEM_LAT=1 and MEM_LAT=4 single reads.
        x_req = 2'b11; x_addr[0] = 32'h40; x_addr[1] = 32'h40;
        for (int g = 0; g < 2; g++) begin
            gc[g] = -1; rc[g] = -1; nrv[g] = 0; rd[g] = 32'h0;
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (x_gnt[g] && gc[g] < 0) gc[g] = k;
                if (x_rvalid[g]) begin
                    nrv[g]++;
                    rc[g] = k;
                    rd[g] = x_rdata[g];
                end
            end
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++)
                if (gc[g] >= 0) x_req[g] = 1'b0;
        end
        check_val("lat1_gnt", gc[0], 0);
        check_val("lat4_gnt", gc[1], 0);
        check_val("lat1_rv_cyc", rc[0], 3);
        check_val("lat4_rv_cyc", rc[1], 6);
        check_val("lat1_rdata", rd[0], 32'h5A5A_0040);
        check_val("lat4_rdata", rd[1], 32'h5A5A_0040);
        check_val("lat1_rv_cnt", nrv[0], 1);
        check_val("lat4_rv_cnt", nrv[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
